// File: rtl/seg7_scan_io.sv
// LED register plus a time-multiplexed seven-segment display bank for the IO space.
// Digits are scanned one slot at a time, with a dead-time window at the start of each slot.
module seg7_scan_io #(
    parameter int NUM_DIGITS     = 4,
    parameter int NUM_LEDS       = 4,
    parameter int REFRESH_DIV    = 4096,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic [3:0]            addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wmask,
    input  logic                  rstrb,
    output logic [31:0]           rdata,
    output logic [NUM_LEDS-1:0]   leds,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en
);

    localparam int                    CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]            IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        OFF,
        DEAD,
        ON
    } scan_state_t;

    logic                  wrEn;
    logic                  rdEn;
    logic [31:0]           byteMask;

    logic [NUM_LEDS-1:0]   ledsQ, ledsD;
    logic                  enQ, enD;
    logic                  hexModeQ, hexModeD;
    logic [NUM_DIGITS-1:0] blankQ, blankD;
    logic [31:0]           hexQ, hexD;
    logic [6:0]            rawQ [NUM_DIGITS];
    logic [6:0]            rawD [NUM_DIGITS];

    scan_state_t           stateQ, stateD;
    logic [CNT_W-1:0]      cntQ, cntD;
    logic [2:0]            idxQ, idxD;

    logic [6:0]            pattern;
    logic [NUM_DIGITS-1:0] digOneHot;
    logic [6:0]            segQ, segD;
    logic [NUM_DIGITS-1:0] digEnQ, digEnD;
    logic [31:0]           rdataQ, rdataD;

    assign wrEn     = sel & (|wmask);
    assign rdEn     = sel & rstrb;
    assign byteMask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

    function automatic logic [6:0] hexSeg(input logic [3:0] v);
        case (v)
            4'h0: hexSeg = 7'h7E;
            4'h1: hexSeg = 7'h30;
            4'h2: hexSeg = 7'h6D;
            4'h3: hexSeg = 7'h79;
            4'h4: hexSeg = 7'h33;
            4'h5: hexSeg = 7'h5B;
            4'h6: hexSeg = 7'h5F;
            4'h7: hexSeg = 7'h70;
            4'h8: hexSeg = 7'h7F;
            4'h9: hexSeg = 7'h7B;
            4'hA: hexSeg = 7'h77;
            4'hB: hexSeg = 7'h1F;
            4'hC: hexSeg = 7'h4E;
            4'hD: hexSeg = 7'h3D;
            4'hE: hexSeg = 7'h4F;
            default: hexSeg = 7'h47;
        endcase
    endfunction

    // Register writes, merged per byte lane; RAW registers only live in byte 0.
    always_comb begin
        ledsD    = ledsQ;
        enD      = enQ;
        hexModeD = hexModeQ;
        blankD   = blankQ;
        hexD     = hexQ;
        rawD     = rawQ;
        if (wrEn) begin
            case (addr)
                4'd0: ledsD = (ledsQ & ~byteMask[NUM_LEDS-1:0])
                            | (wdata[NUM_LEDS-1:0] & byteMask[NUM_LEDS-1:0]);
                4'd1: begin
                    if (wmask[0]) begin
                        enD      = wdata[0];
                        hexModeD = wdata[1];
                    end
                    if (wmask[1]) begin
                        blankD = wdata[8 +: NUM_DIGITS];
                    end
                end
                4'd2: hexD = (hexQ & ~byteMask) | (wdata & byteMask);
                default: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (addr == 4'(3 + i) && wmask[0]) begin
                            rawD[i] = wdata[6:0];
                        end
                    end
                end
            endcase
        end
    end

    // Scan sequencing: DEAD versus ON is purely a function of the position inside the slot.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        idxD   = idxQ;
        if (!enQ) begin
            stateD = OFF;
            cntD   = '0;
            idxD   = '0;
        end else begin
            if (stateQ == OFF) begin
                cntD = '0;
                idxD = '0;
            end else if (cntQ == CNT_LAST) begin
                cntD = '0;
                idxD = (idxQ == IDX_LAST) ? 3'd0 : idxQ + 3'd1;
            end else begin
                cntD = cntQ + 1'b1;
            end
            stateD = (cntD < CNT_BLANK) ? DEAD : ON;
        end
    end

    // Outputs are registered alongside the scan state so seg and dig_en switch on the same edge.
    always_comb begin
        pattern   = '0;
        digOneHot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idxD == 3'(i)) begin
                digOneHot[i] = 1'b1;
                if (!blankQ[i]) begin
                    pattern = hexModeQ ? hexSeg(hexQ[4*i +: 4]) : rawQ[i];
                end
            end
        end
        segD   = SEG_OFF;
        digEnD = DIG_OFF;
        if (stateD != OFF) begin
            segD = pattern ^ SEG_OFF;
        end
        if (stateD == ON) begin
            digEnD = digOneHot ^ DIG_OFF;
        end
    end

    // Readback sees the pre-write register values, so a same-cycle write returns old data.
    always_comb begin
        rdataD = rdataQ;
        if (rdEn) begin
            rdataD = '0;
            case (addr)
                4'd0: rdataD[NUM_LEDS-1:0] = ledsQ;
                4'd1: begin
                    rdataD[0]              = enQ;
                    rdataD[1]              = hexModeQ;
                    rdataD[8 +: NUM_DIGITS] = blankQ;
                    rdataD[26:24]          = idxQ;
                end
                4'd2: rdataD = hexQ;
                default: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (addr == 4'(3 + i)) begin
                            rdataD[6:0] = rawQ[i];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ledsQ    <= '0;
            enQ      <= 1'b0;
            hexModeQ <= 1'b0;
            blankQ   <= '0;
            hexQ     <= '0;
            rawQ     <= '{default: '0};
            stateQ   <= OFF;
            cntQ     <= '0;
            idxQ     <= '0;
            segQ     <= SEG_OFF;
            digEnQ   <= DIG_OFF;
            rdataQ   <= '0;
        end else begin
            ledsQ    <= ledsD;
            enQ      <= enD;
            hexModeQ <= hexModeD;
            blankQ   <= blankD;
            hexQ     <= hexD;
            rawQ     <= rawD;
            stateQ   <= stateD;
            cntQ     <= cntD;
            idxQ     <= idxD;
            segQ     <= segD;
            digEnQ   <= digEnD;
            rdataQ   <= rdataD;
        end
    end

    assign rdata  = rdataQ;
    assign leds   = ledsQ;
    assign seg    = segQ;
    assign dig_en = digEnQ;

endmodule

// File: tb/tb_seg7_scan_io.sv
// Bench for seg7_scan_io: a time-based display model checked every cycle,
// plus directed register and scan scenarios with literal expectations.
module tb_seg7_scan_io;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [31:0] rdata;
    logic [3:0]  leds;
    logic [6:0]  seg;
    logic [3:0]  dig_en;

    int checks = 0;
    int passes = 0;

    seg7_scan_io #(
        .NUM_DIGITS(ND), .NUM_LEDS(4), .REFRESH_DIV(RD), .BLANK_CYCLES(BC),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .wdata(wdata),
        .wmask(wmask), .rstrb(rstrb), .rdata(rdata), .leds(leds),
        .seg(seg), .dig_en(dig_en)
    );

    always #5 clk = ~clk;

    logic [6:0] hexTable [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Model: registers plus "cycles since the scan started"; digit and phase come from division.
    logic [3:0]  mLeds;
    logic        mEn, mHexMode;
    logic [3:0]  mBlank;
    logic [31:0] mHex;
    logic [6:0]  mRaw [ND];
    logic        mOn;
    int          mT;
    logic [31:0] mRdata;
    logic [6:0]  mSeg;
    logic [3:0]  mDig;
    logic        modelValid = 1'b0;

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] m);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    function automatic int curDigit(input logic on, input int t);
        return on ? (t / RD) % ND : 0;
    endfunction

    function automatic logic [6:0] digitPattern(input int d);
        if (mBlank[d]) return 7'h00;
        return mHexMode ? hexTable[mHex[4*d +: 4]] : mRaw[d];
    endfunction

    function automatic logic [31:0] readReg(input logic [3:0] a);
        logic [31:0] r = '0;
        case (a)
            4'd0: r[3:0] = mLeds;
            4'd1: begin
                r[0]     = mEn;
                r[1]     = mHexMode;
                r[11:8]  = mBlank;
                r[26:24] = 3'(curDigit(mOn, mT));
            end
            4'd2: r = mHex;
            4'd3, 4'd4, 4'd5, 4'd6: r[6:0] = mRaw[a - 4'd3];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int nextT();
        return (mEn && mOn) ? mT + 1 : 0;
    endfunction

    function automatic logic [6:0] expSeg();
        return mEn ? (7'h7F ^ digitPattern(curDigit(1'b1, nextT()))) : 7'h7F;
    endfunction

    function automatic logic [3:0] expDig();
        if (mEn && (nextT() % RD) >= BC) return 4'(1 << curDigit(1'b1, nextT()));
        return 4'h0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mLeds <= '0; mEn <= 1'b0; mHexMode <= 1'b0; mBlank <= '0; mHex <= '0;
            mRaw <= '{default: '0}; mOn <= 1'b0; mT <= 0; mRdata <= '0;
            mSeg <= 7'h7F; mDig <= 4'h0; modelValid <= 1'b1;
        end else begin
            if (sel && rstrb) mRdata <= readReg(addr);
            if (sel && wmask != 4'h0) begin
                case (addr)
                    4'd0: mLeds <= 4'(mergeBytes({28'b0, mLeds}, wdata, wmask));
                    4'd1: begin
                        if (wmask[0]) begin mEn <= wdata[0]; mHexMode <= wdata[1]; end
                        if (wmask[1]) mBlank <= wdata[11:8];
                    end
                    4'd2: mHex <= mergeBytes(mHex, wdata, wmask);
                    4'd3, 4'd4, 4'd5, 4'd6: if (wmask[0]) mRaw[addr - 4'd3] <= wdata[6:0];
                    default: ;
                endcase
            end
            mOn  <= mEn;
            mT   <= nextT();
            mSeg <= expSeg();
            mDig <= expDig();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("modelSeg", {25'b0, seg}, {25'b0, mSeg});
            checkOutput("modelDig", {28'b0, dig_en}, {28'b0, mDig});
            checkOutput("modelLeds", {28'b0, leds}, {28'b0, mLeds});
            checkOutput("modelRdata", rdata, mRdata);
        end
    end

    task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d,
                                 input logic [3:0] m, input logic rd);
        sel = 1'b1; addr = a; wdata = d; wmask = m; rstrb = rd;
        @(negedge clk);
        sel = 1'b0; wmask = 4'h0; rstrb = 1'b0;
    endtask

    task automatic waitDig(input string name, input logic [3:0] want, input int maxCycles);
        int n = 0;
        while (dig_en !== want && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {28'b0, dig_en}, {28'b0, want});
    endtask

    logic [6:0] hexSegLit [4] = '{7'h01, 7'h4F, 7'h12, 7'h06};

    initial begin
        reset = 1'b1; sel = 1'b0; addr = '0; wdata = '0; wmask = '0; rstrb = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("idleSeg", {25'b0, seg}, 32'h7F);
        checkOutput("idleDig", {28'b0, dig_en}, 32'h0);
        checkOutput("idleLeds", {28'b0, leds}, 32'h0);
        applyStimulus(4'd1, 32'h0, 4'h0, 1'b1);
        checkOutput("idleCtrlRead", rdata, 32'h0);

        // Hex scan over all four digits including the wrap back to digit 0.
        applyStimulus(4'd2, 32'h0000_3210, 4'hF, 1'b0);
        applyStimulus(4'd1, 32'h0000_0003, 4'h1, 1'b0);
        checkOutput("enLatencySeg", {25'b0, seg}, 32'h7F);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checkOutput("scanSeg", {25'b0, seg}, {25'b0, hexSegLit[(k / 8) % 4]});
            checkOutput("scanDig", {28'b0, dig_en},
                        ((k % 8) < 2) ? 32'h0 : (32'h1 << ((k / 8) % 4)));
        end
        waitDig("waitDigit2", 4'b0100, 40);
        applyStimulus(4'd1, 32'h0, 4'h0, 1'b1);
        checkOutput("curReadback", rdata, 32'h0200_0003);

        // Raw mode with digit 2 force-blanked.
        applyStimulus(4'd1, 32'h0000_0401, 4'h3, 1'b0);
        applyStimulus(4'd5, 32'h0000_007F, 4'h1, 1'b0);
        applyStimulus(4'd4, 32'h0000_0006, 4'h1, 1'b0);
        applyStimulus(4'd3, 32'h0000_007F, 4'b0010, 1'b0);
        waitDig("waitBlanked", 4'b0100, 40);
        checkOutput("blankedSeg", {25'b0, seg}, 32'h7F);
        waitDig("waitRaw1", 4'b0010, 40);
        checkOutput("raw1Seg", {25'b0, seg}, 32'h79);
        waitDig("waitRaw0", 4'b0001, 40);
        checkOutput("raw0NoLane0", {25'b0, seg}, 32'h7F);
        applyStimulus(4'd5, 32'h0, 4'h0, 1'b1);
        checkOutput("raw2Read", rdata, 32'h7F);
        applyStimulus(4'd7, 32'h0, 4'h0, 1'b1);
        checkOutput("raw4Unmapped", rdata, 32'h0);

        // LED byte lanes, unmapped index, read-during-write and BLANK readback width.
        applyStimulus(4'd0, 32'hFFFF_FFFF, 4'b0001, 1'b0);
        checkOutput("ledsLane0", {28'b0, leds}, 32'hF);
        applyStimulus(4'd0, 32'h0, 4'b0010, 1'b0);
        checkOutput("ledsLane1Only", {28'b0, leds}, 32'hF);
        applyStimulus(4'd9, 32'hFFFF_FFFF, 4'hF, 1'b0);
        applyStimulus(4'd9, 32'h0, 4'h0, 1'b1);
        checkOutput("unmappedRead", rdata, 32'h0);
        applyStimulus(4'd0, 32'h5, 4'h1, 1'b1);
        checkOutput("readDuringWrite", rdata, 32'hF);
        checkOutput("ledsAfterRdw", {28'b0, leds}, 32'h5);
        applyStimulus(4'd0, 32'h0, 4'h0, 1'b1);
        checkOutput("ledsRead", rdata, 32'h5);
        applyStimulus(4'd1, 32'h0000_FF01, 4'h3, 1'b0);
        applyStimulus(4'd1, 32'h0, 4'h0, 1'b1);
        checkOutput("blankReadWidth", {8'b0, rdata[23:0]}, 32'h0000_0F01);

        // EN cleared mid-ON, then reset in the middle of a new scan.
        waitDig("waitBeforeClear", 4'b0010, 40);
        applyStimulus(4'd1, 32'h0, 4'h1, 1'b0);
        @(negedge clk);
        checkOutput("enClearSeg", {25'b0, seg}, 32'h7F);
        checkOutput("enClearDig", {28'b0, dig_en}, 32'h0);
        applyStimulus(4'd1, 32'h0, 4'h0, 1'b1);
        checkOutput("enClearCur", {29'b0, rdata[26:24]}, 32'h0);
        applyStimulus(4'd1, 32'h3, 4'h1, 1'b0);
        waitDig("waitRescan", 4'b0001, 20);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("resetSeg", {25'b0, seg}, 32'h7F);
        checkOutput("resetDig", {28'b0, dig_en}, 32'h0);
        checkOutput("resetLeds", {28'b0, leds}, 32'h0);
        reset = 1'b0;
        applyStimulus(4'd1, 32'h0, 4'h0, 1'b1);
        checkOutput("resetCtrlRead", rdata, 32'h0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
